mips_cpu_store_unit: RTL and testbench
======================================

// Module: mips_cpu_store_unit
// PURPOSE
// - Store-side counterpart of the register-file partial-load path: turns sb/sh/sw/swl/swr into one aligned
//   32-bit memory write with byte enables (little-endian, lane k = bits 8k+7:8k).
// - Sits between EX (effective address, rt value) and the data-memory bus; holds busy to stall the CPU
//   while the bus asserts waitrequest; flags misaligned stores and bus timeouts.
// PARAMETERS
// - TIMEOUT_CYCLES  default 16  max cycles mem_write may stall on waitrequest before bus_err; 0 = never time out
// PORTS
// - clk              in   1   clock, all state updates on posedge
// - rst              in   1   reset, asynchronous, active-high
// - start            in   1   request a store this cycle (sampled only in IDLE)
// - opcode           in   6   instruction opcode [31:26]
// - eff_addr         in  32   effective byte address (base + offset)
// - rt_data          in  32   value of rt to be stored
// - busy             out  1   state != IDLE; CPU stalls while high
// - done             out  1   one-cycle pulse: store finished (or rejected)
// - addr_err         out  1   valid with done: misaligned sh/sw, no bus cycle issued
// - bus_err          out  1   valid with done: waitrequest timeout, write abandoned
// - mem_address      out 32   word address {eff_addr[31:2],2'b00}
// - mem_write        out  1   write strobe
// - mem_writedata    out 32   lane-aligned data
// - mem_byteenable   out  4   active lanes
// - mem_waitrequest  in   1   bus not ready; outputs must hold stable while high
// BEHAVIOUR
// - Reset (async): state IDLE; busy, done, addr_err, bus_err, mem_write = 0; mem_address, mem_writedata = 0;
//   mem_byteenable = 4'b0000; timeout counter = 0. Reset mid-write drops mem_write immediately.
// - Opcodes: sb 101000, sh 101001, swl 101010, sw 101011, swr 101110. start with any other opcode is ignored.
// - Lane map by off = eff_addr[1:0]:
//   sb : be = 4'b0001<<off; data = {4{rt[7:0]}}
//   sh : off 0 be 0011, off 2 be 1100, data {2{rt[15:0]}}; off 1/3 -> addr_err
//   sw : off 0 be 1111, data rt; off != 0 -> addr_err
//   swl: data = rt >> 8*(3-off); be off0 0001, off1 0011, off2 0111, off3 1111
//   swr: data = rt << 8*off;     be off0 1111, off1 1110, off2 1100, off3 1000
// - FSM IDLE -> ISSUE -> RESP -> IDLE:
//   IDLE : start & valid store & aligned -> register address/data/be, go ISSUE.
//          start & misaligned -> go RESP with addr_err latched; no bus cycle.
//   ISSUE: mem_write=1, outputs held. Edge with waitrequest=0 -> RESP. Counter increments each edge with
//          waitrequest=1; reaching TIMEOUT_CYCLES -> RESP with bus_err latched, mem_write drops.
//   RESP : done=1 for exactly one cycle (errors valid with it), then IDLE; errors clear on leaving RESP.
// - Latency: start at edge N -> mem_write high N..N+1; zero-wait bus -> done high N+1..N+2 (2 cycles total).
// - start while busy: ignored (CPU guarantees stall). busy covers ISSUE and RESP.
// - mem_byteenable/mem_writedata are 0 whenever mem_write = 0.
// STRUCTURE
// - Shared package mips_cpu_pkg: opcode localparams (OP_SB..OP_SWR), store_state_t enum {IDLE,ISSUE,RESP}.
// - One sub-module: mips_cpu_store_align (combinational opcode/off/rt -> data, be, misaligned, is_store);
//   FSM, counter and output registers stay in this module.
// TESTING
// - sb, eff_addr=0x103, rt=0x000000AB, no wait -> addr 0x100, be 1000, data 0xABABABAB, done 2 cycles after start.
// - sh eff_addr=0x202 rt=0x1234 -> be 1100, data 0x12341234; sh eff_addr=0x201 -> no mem_write, done+addr_err.
// - swl off1 rt=0xAABBCCDD -> be 0011, data[15:0]=0xAABB; swr off1 same rt -> be 1110, data 0xBBCCDD00.
// - sw with waitrequest high 5 cycles -> outputs stable throughout, done 1 cycle after waitrequest falls.
// - TIMEOUT_CYCLES=4, waitrequest stuck high -> mem_write drops after 4 stalled edges, done+bus_err pulse.
// - rst asserted mid-ISSUE -> mem_write, busy low immediately; start next cycle after release works normally.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: store opcodes and store-unit FSM states.
package mips_cpu_pkg;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } store_state_t;

endpackage

// File: rtl/mips_cpu_store_align.sv
// Combinational lane steering for stores: opcode, byte offset and rt value
// become little-endian lane data plus byte enables.
module mips_cpu_store_align
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rt_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o,
  output logic        misaligned_o,
  output logic        is_store_o
);

  // Shift amounts for the unaligned-word pair: swl keeps the top (off+1)
  // bytes of rt, moved down to the bottom lanes; swr moves rt up by off.
  logic [1:0] inv_off;
  logic [4:0] swl_sh;
  logic [4:0] swr_sh;

  assign inv_off = 2'd3 - off_i;
  assign swl_sh  = {inv_off, 3'b000};
  assign swr_sh  = {off_i, 3'b000};

  // Decode opcode into lane data, enables and alignment fault.
  always_comb begin
    data_o       = 32'd0;
    be_o         = 4'b0000;
    misaligned_o = 1'b0;
    is_store_o   = 1'b0;
    case (opcode_i)
      OP_SB: begin
        is_store_o = 1'b1;
        be_o       = 4'b0001 << off_i;
        data_o     = {4{rt_i[7:0]}};
      end
      OP_SH: begin
        is_store_o   = 1'b1;
        misaligned_o = off_i[0];
        be_o         = off_i[1] ? 4'b1100 : 4'b0011;
        data_o       = {2{rt_i[15:0]}};
      end
      OP_SW: begin
        is_store_o   = 1'b1;
        misaligned_o = (off_i != 2'd0);
        be_o         = 4'b1111;
        data_o       = rt_i;
      end
      OP_SWL: begin
        is_store_o = 1'b1;
        be_o       = 4'b1111 >> inv_off;
        data_o     = rt_i >> swl_sh;
      end
      OP_SWR: begin
        is_store_o = 1'b1;
        be_o       = 4'b1111 << off_i;
        data_o     = rt_i << swr_sh;
      end
      default: begin
        is_store_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_store_unit.sv
// Store unit: turns sb/sh/sw/swl/swr into a single aligned 32-bit bus write,
// stalls the CPU while the bus waits, and reports misalignment and timeouts.
module mips_cpu_store_unit
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] eff_addr,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest
);

  localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES;

  store_state_t state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   be_q, be_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         aerr_q, aerr_d;
  logic         berr_q, berr_d;

  logic [31:0]  al_data;
  logic [3:0]   al_be;
  logic         al_misaligned;
  logic         al_is_store;

  mips_cpu_store_align u_align (
    .opcode_i     (opcode),
    .off_i        (eff_addr[1:0]),
    .rt_i         (rt_data),
    .data_o       (al_data),
    .be_o         (al_be),
    .misaligned_o (al_misaligned),
    .is_store_o   (al_is_store)
  );

  // State, captured write and error flags; async reset drops the bus cycle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'b0000;
      cnt_q   <= 32'd0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
    end
  end

  // Next-state logic: accept in IDLE, hold the write in ISSUE, pulse in RESP.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    aerr_d  = aerr_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        aerr_d = 1'b0;
        berr_d = 1'b0;
        cnt_d  = 32'd0;
        if (start && al_is_store) begin
          if (al_misaligned) begin
            aerr_d  = 1'b1;
            state_d = RESP;
          end else begin
            addr_d  = {eff_addr[31:2], 2'b00};
            wdata_d = al_data;
            be_d    = al_be;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!mem_waitrequest) begin
          cnt_d   = 32'd0;
          state_d = RESP;
        end else if ((TO_LIMIT != 32'd0) && (cnt_q + 32'd1 == TO_LIMIT)) begin
          cnt_d   = 32'd0;
          berr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus strobe follows ISSUE; lane data and enables are forced to zero outside it.
  always_comb begin
    mem_write      = (state_q == ISSUE);
    busy           = (state_q != IDLE);
    done           = (state_q == RESP);
    addr_err       = aerr_q;
    bus_err        = berr_q;
    mem_address    = addr_q;
    mem_writedata  = mem_write ? wdata_q : 32'd0;
    mem_byteenable = mem_write ? be_q : 4'b0000;
  end

endmodule

// File: tb/tb_mips_cpu_store_unit.sv
// Directed bench for the store unit: lane mapping, handshake, stalls,
// misalignment, bus timeout and asynchronous reset.
module tb_mips_cpu_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] eff_addr = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        waitreq = 1'b0;
  logic        busy, done, addr_err, bus_err, mem_write;
  logic [31:0] mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;

  logic        start_b = 1'b0;
  logic [5:0]  opcode_b = 6'd0;
  logic [31:0] eff_addr_b = 32'd0;
  logic [31:0] rt_data_b = 32'd0;
  logic        waitreq_b = 1'b0;
  logic        busy_b, done_b, addr_err_b, bus_err_b, mem_write_b;
  logic [31:0] mem_address_b, mem_writedata_b;
  logic [3:0]  mem_byteenable_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_cpu_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .eff_addr(eff_addr), .rt_data(rt_data),
    .busy(busy), .done(done), .addr_err(addr_err), .bus_err(bus_err),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(waitreq)
  );

  mips_cpu_store_unit #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .rst(rst), .start(start_b), .opcode(opcode_b),
    .eff_addr(eff_addr_b), .rt_data(rt_data_b),
    .busy(busy_b), .done(done_b), .addr_err(addr_err_b), .bus_err(bus_err_b),
    .mem_address(mem_address_b), .mem_write(mem_write_b),
    .mem_writedata(mem_writedata_b), .mem_byteenable(mem_byteenable_b),
    .mem_waitrequest(waitreq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; on return the DUT has sampled it.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt);
    start    = 1'b1;
    opcode   = op;
    eff_addr = a;
    rt_data  = rt;
    tick();
    start    = 1'b0;
  endtask

  // Check a zero-wait write that has just entered ISSUE, then its done pulse.
  task automatic chk_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    chk({tag, ".wr"},   {31'd0, mem_write}, 32'd1);
    chk({tag, ".addr"}, mem_address, a);
    chk({tag, ".data"}, mem_writedata, d);
    chk({tag, ".be"},   {28'd0, mem_byteenable}, {28'd0, be});
    chk({tag, ".done0"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".wrlow"}, {31'd0, mem_write}, 32'd0);
    chk({tag, ".below"}, {28'd0, mem_byteenable}, 32'd0);
    chk({tag, ".err"}, {30'd0, addr_err, bus_err}, 32'd0);
    tick();
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.wr", {31'd0, mem_write}, 32'd0);
    chk("rst.addr", mem_address, 32'd0);
    chk("rst.data", mem_writedata, 32'd0);
    chk("rst.be", {28'd0, mem_byteenable}, 32'd0);
    chk("rst.err", {30'd0, addr_err, bus_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // sb at offset 3: byte replicated, top lane enabled.
    issue(6'b101000, 32'h0000_0103, 32'h0000_00AB);
    chk("sb.busy", {31'd0, busy}, 32'd1);
    chk_write("sb3", 32'h0000_0100, 32'hABAB_ABAB, 4'b1000);

    issue(6'b101000, 32'h0000_0110, 32'h1234_5677);
    chk_write("sb0", 32'h0000_0110, 32'h7777_7777, 4'b0001);

    // sh upper half.
    issue(6'b101001, 32'h0000_0202, 32'h0000_1234);
    chk_write("sh2", 32'h0000_0200, 32'h1234_1234, 4'b1100);

    // sh misaligned: no bus cycle, done with addr_err next cycle.
    issue(6'b101001, 32'h0000_0201, 32'h0000_1234);
    chk("shmis.wr", {31'd0, mem_write}, 32'd0);
    chk("shmis.done", {31'd0, done}, 32'd1);
    chk("shmis.aerr", {31'd0, addr_err}, 32'd1);
    chk("shmis.berr", {31'd0, bus_err}, 32'd0);
    chk("shmis.busy", {31'd0, busy}, 32'd1);
    tick();
    chk("shmis.clr", {29'd0, busy, done, addr_err}, 32'd0);

    // sw misaligned.
    issue(6'b101011, 32'h0000_0302, 32'hCAFE_F00D);
    chk("swmis.aerr", {30'd0, done, addr_err}, 32'd3);
    chk("swmis.wr", {31'd0, mem_write}, 32'd0);
    tick();

    // swl / swr at offset 1 and swl offset 3.
    issue(6'b101010, 32'h0000_0401, 32'hAABB_CCDD);
    chk_write("swl1", 32'h0000_0400, 32'h0000_AABB, 4'b0011);
    issue(6'b101110, 32'h0000_0401, 32'hAABB_CCDD);
    chk_write("swr1", 32'h0000_0400, 32'hBBCC_DD00, 4'b1110);
    issue(6'b101010, 32'h0000_0403, 32'hAABB_CCDD);
    chk_write("swl3", 32'h0000_0400, 32'hAABB_CCDD, 4'b1111);
    issue(6'b101110, 32'h0000_0403, 32'hAABB_CCDD);
    chk_write("swr3", 32'h0000_0400, 32'hDD00_0000, 4'b1000);

    // Non-store opcode is ignored.
    issue(6'b100011, 32'h0000_0500, 32'h1111_1111);
    chk("lw.ignored", {30'd0, busy, mem_write}, 32'd0);
    tick();
    chk("lw.nodone", {31'd0, done}, 32'd0);

    // sw with five stalled edges: outputs must hold.
    waitreq = 1'b1;
    issue(6'b101011, 32'h0000_0600, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      chk("swst.wr", {31'd0, mem_write}, 32'd1);
      chk("swst.addr", mem_address, 32'h0000_0600);
      chk("swst.data", mem_writedata, 32'hDEAD_BEEF);
      chk("swst.be", {28'd0, mem_byteenable}, 32'hF);
      chk("swst.done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("swst.wr5", {31'd0, mem_write}, 32'd1);
    waitreq = 1'b0;
    tick();
    chk("swst.done1", {31'd0, done}, 32'd1);
    chk("swst.err", {30'd0, addr_err, bus_err}, 32'd0);
    tick();
    chk("swst.idle", {31'd0, busy}, 32'd0);

    // Timeout on the TIMEOUT_CYCLES=4 instance.
    waitreq_b  = 1'b1;
    start_b    = 1'b1;
    opcode_b   = 6'b101011;
    eff_addr_b = 32'h0000_0700;
    rt_data_b  = 32'h0BAD_0BAD;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("to.wr", {31'd0, mem_write_b}, 32'd1);
      chk("to.done", {31'd0, done_b}, 32'd0);
      tick();
    end
    chk("to.wr3", {31'd0, mem_write_b}, 32'd1);
    tick();
    chk("to.wrdrop", {31'd0, mem_write_b}, 32'd0);
    chk("to.done", {31'd0, done_b}, 32'd1);
    chk("to.berr", {31'd0, bus_err_b}, 32'd1);
    chk("to.aerr", {31'd0, addr_err_b}, 32'd0);
    chk("to.be0", {28'd0, mem_byteenable_b}, 32'd0);
    tick();
    chk("to.clr", {29'd0, busy_b, done_b, bus_err_b}, 32'd0);
    waitreq_b = 1'b0;

    // Reset mid-ISSUE, then a normal store right after release.
    waitreq = 1'b1;
    issue(6'b101011, 32'h0000_0800, 32'h5555_AAAA);
    chk("rmid.wr", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid.wrlow", {31'd0, mem_write}, 32'd0);
    chk("rmid.busy", {31'd0, busy}, 32'd0);
    chk("rmid.be", {28'd0, mem_byteenable}, 32'd0);
    #1;
    rst = 1'b0;
    waitreq = 1'b0;
    issue(6'b101000, 32'h0000_0902, 32'h0000_005A);
    chk_write("post", 32'h0000_0900, 32'h5A5A_5A5A, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
